// File: rtl/data_bus_bridge.sv
// Bridges the CPU MEM-stage data port onto a Wishbone-classic master, stalling the pipeline while a cycle is open.
// Optional ack timeout: define MEM_BUS_TIMEOUT_EN to enable the BUSY watchdog and the sticky bus_err_o flag.
module data_bus_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  input  logic              stall_i,
  output logic              stall_req_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [SEL_W-1:0]  wb_sel_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [DATA_W-1:0] wb_dat_o,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack_i,
  output logic              bus_err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   timeout_hit;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Fires on the last permitted BUSY cycle; a real ack in that cycle still wins.
  assign timeout_hit = (state == BUSY) && !wb_ack_i && (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  // Stall is released in the cycle the bus completes so the pipeline can advance with DONE.
  always_comb begin
    stall_req_o = 1'b0;
    case (state)
      IDLE:    stall_req_o = cpu_ce_i;
      BUSY:    stall_req_o = !(wb_ack_i || timeout_hit);
      default: stall_req_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      cpu_data_o <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
      wait_cnt   <= '0;
      bus_err_o  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cpu_data_o <= '0;
          if (cpu_ce_i) begin
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_data_i;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            state    <= BUSY;
`ifdef MEM_BUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            cpu_data_o <= wb_we_o ? '0 : wb_dat_i;
            state      <= DONE;
          end else if (timeout_hit) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            cpu_data_o <= wb_we_o ? '0 : DATA_W'(32'hDEADBEEF);
`ifdef MEM_BUS_TIMEOUT_EN
            bus_err_o  <= 1'b1;
`endif
            state      <= DONE;
          end else begin
`ifdef MEM_BUS_TIMEOUT_EN
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          // MEM/WB captures cpu_data_o on the edge that leaves DONE.
          if (!stall_i) begin
            cpu_data_o <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Randomised self-checking bench for data_bus_bridge; expectations come from a transaction-level model.
module tb_data_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i, stall_i, wb_ack_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_addr_i, cpu_data_i, wb_dat_i;
  logic [31:0] cpu_data_o, wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        stall_req_o, wb_cyc_o, wb_stb_o, wb_we_o, bus_err_o;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  data_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .stall_i(stall_i), .stall_req_o(stall_req_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Observations gathered by run_access
  logic        o_cyc, o_stb, o_we;
  logic [3:0]  o_sel;
  logic [31:0] o_adr, o_dat, o_done_data, o_idle_data;
  int          o_stall_cnt, o_busy_cyc;
  bit          o_stable, o_done_stable, o_done_stall, o_extra;

  // Reference model: what the MEM stage should see once an access has finished
  function automatic logic [31:0] model_rdata(input bit we, input logic [31:0] bus_data);
    return we ? 32'h0 : bus_data;
  endfunction

  // One CPU access. delay = BUSY cycles before the ack cycle, hold = extra cycles stall_i keeps DONE.
  task automatic run_access(input bit we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] rdata,
                            input int delay, input int hold, input bit flush);
    o_stall_cnt = 0; o_busy_cyc = 0; o_stable = 1; o_done_stable = 1;
    o_done_stall = 0; o_extra = 0;
    cpu_ce_i = 1; cpu_we_i = we; cpu_sel_i = sel; cpu_addr_i = addr; cpu_data_i = data;
    wb_ack_i = 0; stall_i = 0;
    #1 if (stall_req_o) o_stall_cnt++;
    @(negedge clk);
    o_cyc = wb_cyc_o; o_stb = wb_stb_o; o_we = wb_we_o;
    o_sel = wb_sel_o; o_adr = wb_adr_o; o_dat = wb_dat_o;
    for (int k = 0; k <= delay; k++) begin
      if (flush && k > 0) cpu_ce_i = 0;
      cpu_addr_i = $urandom; cpu_data_i = $urandom;
      wb_ack_i = (k == delay);
      wb_dat_i = (k == delay) ? rdata : $urandom;
      #1;
      if (stall_req_o) o_stall_cnt++;
      if (wb_cyc_o && wb_stb_o) o_busy_cyc++;
      if (wb_adr_o !== o_adr || wb_dat_o !== o_dat || wb_sel_o !== o_sel || wb_we_o !== o_we)
        o_stable = 0;
      @(negedge clk);
    end
    o_done_data = cpu_data_o;
    cpu_ce_i = !flush;
    for (int j = 0; j <= hold; j++) begin
      stall_i  = (j < hold);
      wb_ack_i = 1'($urandom_range(0, 1));
      wb_dat_i = $urandom;
      #1;
      if (cpu_data_o !== o_done_data) o_done_stable = 0;
      if (stall_req_o) o_done_stall = 1;
      if (wb_cyc_o || wb_stb_o) o_extra = 1;
      @(negedge clk);
    end
    o_idle_data = cpu_data_o;
    if (wb_cyc_o) o_extra = 1;
    stall_i = 0; cpu_ce_i = 0; wb_ack_i = 0;
  endtask

  task automatic test_reset;
    rst = 1; cpu_ce_i = 0; cpu_we_i = 0; cpu_sel_i = 0; cpu_addr_i = 0; cpu_data_i = 0;
    stall_i = 0; wb_ack_i = 0; wb_dat_i = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, stall_req_o, bus_err_o} !== 5'b0 ||
        wb_sel_o !== 4'h0 || wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || cpu_data_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: cyc=%b stb=%b we=%b stall=%b err=%b adr=%h dat=%h rd=%h, required all zero",
               wb_cyc_o, wb_stb_o, wb_we_o, stall_req_o, bus_err_o, wb_adr_o, wb_dat_o, cpu_data_o);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_load;
    run_access(1'b0, 4'b1111, 32'h10, 32'h0, 32'h12345678, 3, 0, 1'b0);
    checks++;
    if (o_stall_cnt !== 4) begin failures++; $display("FAIL load_stall_cycles: got %0d required 4", o_stall_cnt); end
    checks++;
    if (o_done_data !== 32'h12345678) begin failures++; $display("FAIL load_data: got %h required 12345678", o_done_data); end
    checks++;
    if (o_adr !== 32'h10 || o_we !== 1'b0 || o_cyc !== 1'b1 || o_stb !== 1'b1) begin
      failures++; $display("FAIL load_bus: adr=%h we=%b cyc=%b stb=%b, required adr=10 we=0 cyc=1 stb=1", o_adr, o_we, o_cyc, o_stb);
    end
    checks++;
    if (o_idle_data !== 32'h0) begin failures++; $display("FAIL load_idle_clear: got %h required 0", o_idle_data); end
  endtask

  task automatic test_store;
    run_access(1'b1, 4'b0011, 32'h20, 32'hAABBCCDD, 32'hFFFF0000, 0, 0, 1'b0);
    checks++;
    if (o_dat !== 32'hAABBCCDD || o_sel !== 4'b0011 || o_we !== 1'b1) begin
      failures++; $display("FAIL store_bus: dat=%h sel=%b we=%b, required AABBCCDD 0011 1", o_dat, o_sel, o_we);
    end
    checks++;
    if (o_busy_cyc !== 1 || o_stall_cnt !== 1) begin
      failures++; $display("FAIL store_timing: cyc_cycles=%0d stall_cycles=%0d, required 1 and 1", o_busy_cyc, o_stall_cnt);
    end
    checks++;
    if (o_done_data !== 32'h0) begin failures++; $display("FAIL store_rdata: got %h required 0", o_done_data); end
  endtask

  task automatic test_stall_hold;
    run_access(1'b0, 4'b1111, 32'h44, 32'h0, 32'hCAFEF00D, 1, 2, 1'b0);
    checks++;
    if (!o_done_stable || o_done_data !== 32'hCAFEF00D) begin
      failures++; $display("FAIL hold_data: got %h stable=%0d, required CAFEF00D stable=1", o_done_data, o_done_stable);
    end
    checks++;
    if (o_extra || o_done_stall) begin
      failures++; $display("FAIL hold_no_new_cycle: extra_cyc=%0d stall_in_done=%0d, required 0 0", o_extra, o_done_stall);
    end
    checks++;
    if (o_idle_data !== 32'h0) begin failures++; $display("FAIL hold_release: got %h required 0", o_idle_data); end
  endtask

  task automatic test_flush;
    run_access(1'b0, 4'b1111, 32'h80, 32'h0, 32'h55, 3, 0, 1'b1);
    checks++;
    if (o_busy_cyc !== 4 || o_stall_cnt !== 4 || o_done_data !== 32'h55) begin
      failures++; $display("FAIL flush_complete: cyc_cycles=%0d stall=%0d data=%h, required 4 4 00000055", o_busy_cyc, o_stall_cnt, o_done_data);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b0 || o_extra || stall_req_o !== 1'b0) begin
      failures++; $display("FAIL flush_idle: cyc=%b extra=%0d stall=%b, required 0 0 0", wb_cyc_o, o_extra, stall_req_o);
    end
  endtask

  task automatic test_async_reset;
    cpu_ce_i = 1; cpu_we_i = 0; cpu_sel_i = 4'hF; cpu_addr_i = 32'h100; wb_ack_i = 0;
    @(negedge clk);
    cpu_ce_i = 0;
    checks++;
    if (wb_cyc_o !== 1'b1) begin failures++; $display("FAIL arst_busy: cyc=%b required 1", wb_cyc_o); end
    #2 rst = 1;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || stall_req_o !== 1'b0) begin
      failures++; $display("FAIL arst_drop: cyc=%b stb=%b stall=%b, required 0 0 0", wb_cyc_o, wb_stb_o, stall_req_o);
    end
    @(negedge clk);
    rst = 0; wb_ack_i = 1; wb_dat_i = 32'h99;
    @(negedge clk);
    wb_ack_i = 0;
    checks++;
    if (wb_cyc_o !== 1'b0 || cpu_data_o !== 32'h0 || stall_req_o !== 1'b0) begin
      failures++; $display("FAIL arst_late_ack: cyc=%b data=%h stall=%b, required 0 0 0", wb_cyc_o, cpu_data_o, stall_req_o);
    end
  endtask

  task automatic test_back_to_back;
    int start;
    start = edge_cnt;
    for (int i = 0; i < 4; i++) begin
      run_access(1'(i & 1), 4'hF, 32'h200 + 32'(i * 4), $urandom, 32'h1000 + 32'(i), 0, 0, 1'b0);
      checks++;
      if (o_done_data !== model_rdata(1'(i & 1), 32'h1000 + 32'(i))) begin
        failures++; $display("FAIL b2b_data[%0d]: got %h required %h", i, o_done_data, model_rdata(1'(i & 1), 32'h1000 + 32'(i)));
      end
    end
    checks++;
    if (edge_cnt - start !== 12) begin failures++; $display("FAIL b2b_spacing: got %0d cycles required 12", edge_cnt - start); end
  endtask

  task automatic test_random;
    bit we; logic [3:0] sel; logic [31:0] addr, data, rdata; int delay, hold;
    for (int n = 0; n < 25; n++) begin
      we = 1'($urandom_range(0, 1)); sel = 4'($urandom_range(0, 15));
      addr = $urandom; data = $urandom; rdata = $urandom;
      delay = $urandom_range(0, 5); hold = $urandom_range(0, 2);
      run_access(we, sel, addr, data, rdata, delay, hold, 1'b0);
      checks++;
      if (o_adr !== addr || o_sel !== sel || o_we !== we || o_dat !== data || !o_stable) begin
        failures++; $display("FAIL rand_bus[%0d]: adr=%h sel=%h we=%b dat=%h stable=%0d, required %h %h %b %h 1",
                             n, o_adr, o_sel, o_we, o_dat, o_stable, addr, sel, we, data);
      end
      checks++;
      if (o_stall_cnt !== delay + 1 || o_busy_cyc !== delay + 1) begin
        failures++; $display("FAIL rand_timing[%0d]: stall=%0d cyc=%0d, required %0d", n, o_stall_cnt, o_busy_cyc, delay + 1);
      end
      checks++;
      if (o_done_data !== model_rdata(we, rdata) || !o_done_stable || o_idle_data !== 32'h0 || o_extra) begin
        failures++; $display("FAIL rand_data[%0d]: done=%h stable=%0d idle=%h extra=%0d, required %h 1 0 0",
                             n, o_done_data, o_done_stable, o_idle_data, o_extra, model_rdata(we, rdata));
      end
    end
    checks++;
    if (bus_err_o !== 1'b0) begin failures++; $display("FAIL rand_no_err: bus_err=%b required 0", bus_err_o); end
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  task automatic test_timeout;
    cpu_ce_i = 1; cpu_we_i = 0; cpu_sel_i = 4'hF; cpu_addr_i = 32'h300; wb_ack_i = 0; stall_i = 0;
    @(negedge clk);
    cpu_ce_i = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (wb_cyc_o !== 1'b1 || stall_req_o !== 1'b1) begin
      failures++; $display("FAIL timeout_waiting: cyc=%b stall=%b, required 1 1", wb_cyc_o, stall_req_o);
    end
    repeat (2) @(negedge clk);
    stall_i = 1;
    #1;
    checks++;
    if (cpu_data_o !== 32'hDEADBEEF || bus_err_o !== 1'b1 || stall_req_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
      failures++; $display("FAIL timeout_fire: data=%h err=%b stall=%b cyc=%b, required DEADBEEF 1 0 0",
                           cpu_data_o, bus_err_o, stall_req_o, wb_cyc_o);
    end
    @(negedge clk);
    stall_i = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_err_o !== 1'b1) begin failures++; $display("FAIL timeout_sticky: err=%b required 1", bus_err_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store();
    test_stall_hold();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
`ifdef MEM_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
Sits directly downstream of the CPU core's data-memory port (ram_ce/ram_we/ram_sel/ram_addr/ram_data) and converts each single-cycle request into a Wishbone-classic master transaction of arbitrary latency. While a transaction is outstanding it raises a stall request toward the pipeline controller. It returns latched read data to the MEM stage and holds that data until the pipeline advances.

Parameters:
ADDR_W, 32, address width of CPU port and Wishbone adr
DATA_W, 32, data width; SEL_W = DATA_W/8
TIMEOUT, 255, max wait cycles for ack (used only with MEM_BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_ce_i  in  1  request valid from MEM stage (OR-reduced ram_ce_o)
cpu_we_i  in  1  1 = store, 0 = load
cpu_sel_i  in  SEL_W  byte enables
cpu_addr_i  in  ADDR_W  byte address
cpu_data_i  in  DATA_W  store data
cpu_data_o  out  DATA_W  load data to MEM stage
stall_i  in  1  pipeline held by another source this cycle (stall bit of MEM stage)
stall_req_o  out  1  stall request to ctrl
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  SEL_W  Wishbone byte select
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_dat_i  in  DATA_W  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge
bus_err_o  out  1  timeout flag (0 when feature compiled out)

Behaviour:
- Reset (async): state=IDLE; all wb_* outputs 0; cpu_data_o=0; bus_err_o=0; stall_req_o=0.
- States: IDLE, BUSY, DONE.
- IDLE: stall_req_o = cpu_ce_i (combinational, same cycle). If cpu_ce_i=1: register we/sel/addr/data onto wb_we_o/wb_sel_o/wb_adr_o/wb_dat_o, set wb_cyc_o=wb_stb_o=1 next edge, go BUSY. Address and sel are passed through unmodified.
- BUSY: stall_req_o=1; wb outputs are held stable. On wb_ack_i=1:
  - drop cyc/stb at the next edge;
  - latch wb_dat_i into cpu_data_o if load, else cpu_data_o=0;
  - go to DONE.
- Earliest completion: ack seen in the first BUSY cycle gives 2-cycle request-to-DONE latency.
- DONE: stall_req_o=0; cpu_data_o is held. If stall_i=0, go IDLE at the edge, since MEM/WB captures the data that edge; cpu_data_o clears to 0 in IDLE. If stall_i=1, remain in DONE and hold data.
- A new request is accepted only from IDLE. cpu_ce_i during DONE is the same instruction and is ignored.
- cpu_ce_i deasserting during BUSY (flush) does not abort the bus cycle. The transaction completes normally, then the bridge goes to DONE and on to IDLE. stall_req_o stays 1 until ack.
- wb_ack_i outside BUSY is ignored.
- cpu_sel_i=0 with cpu_ce_i=1 still issues a bus cycle with sel=0.
- Back-to-back requests: minimum spacing is IDLE→BUSY→DONE→IDLE, i.e. 3 cycles per access with zero-wait ack.

Optional Feature:
MEM_BUS_TIMEOUT_EN:
- Defined: an 8+ bit counter runs in BUSY. If no ack arrives within TIMEOUT cycles, the bridge drops cyc/stb, sets cpu_data_o=32'hDEADBEEF for loads (0 for stores), sets bus_err_o=1 (sticky until reset), and goes to DONE.
- Undefined: no counter; BUSY waits indefinitely; bus_err_o tied 0.

Test Plan:
1. Load, addr=0x00000010, sel=4'b1111, ack 3 cycles after stb, wb_dat_i=0x12345678 → stall_req_o high 4 cycles; cpu_data_o=0x12345678 in DONE; wb_adr_o=0x10, wb_we_o=0.
2. Store, addr=0x20, sel=4'b0011, data=0xAABBCCDD, zero-wait ack → wb_dat_o=0xAABBCCDD, wb_sel_o=4'b0011, wb_we_o=1; cyc lasts 1 cycle; stall_req_o clears on the ack cycle.
3. Load completes while stall_i=1 for 2 cycles → state DONE for 3 cycles; cpu_data_o stable; no second bus cycle issued.
4. cpu_ce_i dropped mid-BUSY, ack later with 0x55 → bus cycle completes; no new cycle; bridge returns to IDLE.
5. rst asserted mid-BUSY → wb_cyc_o/wb_stb_o drop to 0 asynchronously (before next clk edge); after release, a late ack is ignored.
6. With MEM_BUS_TIMEOUT_EN, TIMEOUT=8, load with no ack → after 8 BUSY cycles, cpu_data_o=0xDEADBEEF, bus_err_o=1, stall_req_o=0.
